// File: rtl/poll_pkg.sv
// Shared constants for the three-channel request collector in front of the polling arbiter.
package poll_pkg;

    localparam int NUM_CH    = 3;
    localparam int CH_A      = 0;
    localparam int CH_B      = 1;
    localparam int CH_C      = 2;
    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/poll_req_counter.sv
// One channel: saturating pending-request counter with sticky overflow and spurious-service flags.
module poll_req_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             trg,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             pending,
    output logic             ovf,
    output logic             spur
);

    localparam logic [CNT_W-1:0] MAX  = '1;
    localparam logic [CNT_W-1:0] ZERO = '0;
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_next;
    logic             ovf_set;
    logic             spur_set;

    always_comb begin
        cnt_next = cnt;
        ovf_set  = 1'b0;
        spur_set = 1'b0;
        case ({req, trg})
            2'b10: begin
                if (cnt == MAX) ovf_set  = 1'b1;
                else            cnt_next = cnt + ONE;
            end
            2'b01: begin
                if (cnt == ZERO) spur_set = 1'b1;
                else             cnt_next = cnt - ONE;
            end
            // A service pulse against an empty counter cannot retire the request arriving with it.
            2'b11: begin
                if (cnt == ZERO) begin
                    cnt_next = ONE;
                    spur_set = 1'b1;
                end
            end
            default: cnt_next = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= ZERO;
            ovf  <= 1'b0;
            spur <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            ovf  <= ovf_set  | (ovf  & ~clr);
            spur <= spur_set | (spur & ~clr);
        end
    end

    // Level request depends on the register only, never on req/trg.
    assign pending = (cnt != ZERO);

endmodule

// File: rtl/poll_req_collector.sv
// Holds request pulses for channels a/b/c and presents level requests to the polling arbiter.
module poll_req_collector
    import poll_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              req_c,
    input  logic              trg_a,
    input  logic              trg_b,
    input  logic              trg_c,
    input  logic              clr_flags,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic [CNT_W-1:0]  pend_a,
    output logic [CNT_W-1:0]  pend_b,
    output logic [CNT_W-1:0]  pend_c,
    output logic [NUM_CH-1:0] ovf,
    output logic [NUM_CH-1:0] spur
);

    poll_req_counter #(.CNT_W(CNT_W)) u_ch_a (
        .clk     (clk),
        .rst     (rst),
        .req     (req_a),
        .trg     (trg_a),
        .clr     (clr_flags),
        .cnt     (pend_a),
        .pending (a),
        .ovf     (ovf[CH_A]),
        .spur    (spur[CH_A])
    );

    poll_req_counter #(.CNT_W(CNT_W)) u_ch_b (
        .clk     (clk),
        .rst     (rst),
        .req     (req_b),
        .trg     (trg_b),
        .clr     (clr_flags),
        .cnt     (pend_b),
        .pending (b),
        .ovf     (ovf[CH_B]),
        .spur    (spur[CH_B])
    );

    poll_req_counter #(.CNT_W(CNT_W)) u_ch_c (
        .clk     (clk),
        .rst     (rst),
        .req     (req_c),
        .trg     (trg_c),
        .clr     (clr_flags),
        .cnt     (pend_c),
        .pending (c),
        .ovf     (ovf[CH_C]),
        .spur    (spur[CH_C])
    );

endmodule
